// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Purpose:
//   Streams a program into the CPU instruction memory, then releases the CPU
//   from reset and supervises its run until it halts. Optionally a watchdog
//   ends a run that exceeds WDOG_LIMIT cycles.
//
// Configuration:
//   PROGRAM_LOADER_WATCHDOG_EN  defined   -> watchdog compiled in, timeout live
//                               undefined -> no watchdog, timeout tied to 0
//
// Parameters:
//   WDOG_LIMIT        maximum RUN cycles before timeout (watchdog builds only)
//
// Ports:
//   CLK               sole clock, rising edge
//   clr               synchronous active-high reset
//   start             begin a new load (honoured in IDLE or DONE only)
//   s_valid/s_ready   instruction stream handshake
//   s_data/s_last     instruction word / final-word marker
//   cpu_clr_n         CPU reset, active-low
//   PC_en             CPU program-counter enable
//   instr2memory_en   imem address-override select
//   I_memory_en       imem write strobe
//   instr2memory_addr imem write address (bits 15:8 always 0)
//   instr_in          imem write data
//   HLT / OutR_D      CPU halt flag / CPU output-register data
//   busy, done, timeout, load_trunc  status flags
//   cycle_count       RUN cycles of the last execution (saturating)
//   out_valid/out_data captured CPU output sample
// -----------------------------------------------------------------------------
module program_loader #(
   parameter logic [15:0] WDOG_LIMIT = 16'hFFFF
) (
   input  logic        CLK,
   input  logic        clr,
   input  logic        start,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [15:0] s_data,
   input  logic        s_last,
   output logic        cpu_clr_n,
   output logic        PC_en,
   output logic        instr2memory_en,
   output logic        I_memory_en,
   output logic [15:0] instr2memory_addr,
   output logic [15:0] instr_in,
   input  logic        HLT,
   input  logic [15:0] OutR_D,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic        load_trunc,
   output logic [15:0] cycle_count,
   output logic        out_valid,
   output logic [15:0] out_data
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_FLUSH   = 3'd2,
      ST_RELEASE = 3'd3,
      ST_RUN     = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [7:0]  word_cnt_r;
   logic [7:0]  word_cnt_s;
   logic [7:0]  wr_addr_r;
   logic [7:0]  wr_addr_s;
   logic [15:0] wr_data_r;
   logic [15:0] wr_data_s;
   logic        wr_en_r;
   logic        wr_en_s;
   logic        trunc_r;
   logic        trunc_s;
   logic [15:0] cyc_cnt_r;
   logic [15:0] cyc_cnt_s;
   logic        out_valid_r;
   logic        out_valid_s;
   logic [15:0] out_data_r;
   logic [15:0] out_data_s;
   logic        s_ready_r;
   logic        s_ready_s;
   logic        imem_sel_r;
   logic        imem_sel_s;
   logic        cpu_clr_n_r;
   logic        cpu_clr_n_s;
   logic        pc_en_r;
   logic        pc_en_s;
   logic        busy_r;
   logic        busy_s;
   logic        done_r;
   logic        done_s;
   logic        new_load_s;
`ifdef PROGRAM_LOADER_WATCHDOG_EN
   logic        timeout_r;
   logic        timeout_s;
`endif

   // Cycle counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] val);
      logic [15:0] res;
      if (val == 16'hFFFF) begin
         res = 16'hFFFF;
      end else begin
         res = val + 16'd1;
      end
      return res;
   endfunction

   // Next-state and next-output computation; every output is registered below.
   always_comb begin
      state_s     = state_r;
      word_cnt_s  = word_cnt_r;
      wr_addr_s   = wr_addr_r;
      wr_data_s   = wr_data_r;
      wr_en_s     = 1'b0;
      trunc_s     = trunc_r;
      cyc_cnt_s   = cyc_cnt_r;
      out_valid_s = 1'b0;
      out_data_s  = out_data_r;
      new_load_s  = 1'b0;
`ifdef PROGRAM_LOADER_WATCHDOG_EN
      timeout_s   = timeout_r;
`endif

      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s    = ST_LOAD;
               new_load_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_LOAD: begin
            // s_ready_r is high throughout LOAD, so it doubles as the accept gate.
            if (s_valid && s_ready_r) begin
               wr_en_s    = 1'b1;
               wr_addr_s  = word_cnt_r;
               wr_data_s  = s_data;
               word_cnt_s = word_cnt_r + 8'd1;
               if (s_last) begin
                  state_s = ST_FLUSH;
               end else if (word_cnt_r == 8'hFF) begin
                  // Memory is full but the stream still has words: stop here.
                  state_s = ST_FLUSH;
                  trunc_s = 1'b1;
               end else begin
                  state_s = ST_LOAD;
               end
            end else begin
               state_s = ST_LOAD;
            end
         end

         ST_FLUSH: begin
            state_s = ST_RELEASE;
         end

         ST_RELEASE: begin
            state_s = ST_RUN;
         end

         ST_RUN: begin
            cyc_cnt_s = sat_inc16(cyc_cnt_r);
            if (OutR_D != 16'h0000) begin
               out_valid_s = 1'b1;
               out_data_s  = OutR_D;
            end else begin
               out_valid_s = 1'b0;
            end
            // Halt wins over a watchdog expiry landing on the same cycle.
            if (HLT) begin
               state_s = ST_DONE;
            end
`ifdef PROGRAM_LOADER_WATCHDOG_EN
            else if (cyc_cnt_s >= WDOG_LIMIT) begin
               state_s   = ST_DONE;
               timeout_s = 1'b1;
            end
`endif
            else begin
               state_s = ST_RUN;
            end
         end

         ST_DONE: begin
            if (start) begin
               state_s    = ST_LOAD;
               new_load_s = 1'b1;
            end else begin
               state_s = ST_DONE;
            end
         end

         default: begin
            state_s = ST_IDLE;
         end
      endcase

      // A fresh load wipes the status of the previous program.
      if (new_load_s) begin
         word_cnt_s = 8'h00;
         trunc_s    = 1'b0;
         cyc_cnt_s  = 16'h0000;
`ifdef PROGRAM_LOADER_WATCHDOG_EN
         timeout_s  = 1'b0;
`endif
      end else begin
         word_cnt_s = word_cnt_s;
      end

      // State-decoded flags are taken from the next state so they register
      // in step with the state itself.
      s_ready_s   = (state_s == ST_LOAD);
      imem_sel_s  = (state_s == ST_LOAD) || (state_s == ST_FLUSH);
      cpu_clr_n_s = (state_s == ST_RELEASE) || (state_s == ST_RUN) ||
                    (state_s == ST_DONE);
      pc_en_s     = (state_s == ST_RUN);
      busy_s      = (state_s == ST_LOAD) || (state_s == ST_FLUSH) ||
                    (state_s == ST_RELEASE) || (state_s == ST_RUN);
      done_s      = (state_s == ST_DONE);
   end

   // State and output registers with synchronous clear.
   always_ff @(posedge CLK) begin
      if (clr) begin
         state_r     <= ST_IDLE;
         word_cnt_r  <= 8'h00;
         wr_addr_r   <= 8'h00;
         wr_data_r   <= 16'h0000;
         wr_en_r     <= 1'b0;
         trunc_r     <= 1'b0;
         cyc_cnt_r   <= 16'h0000;
         out_valid_r <= 1'b0;
         out_data_r  <= 16'h0000;
         s_ready_r   <= 1'b0;
         imem_sel_r  <= 1'b0;
         cpu_clr_n_r <= 1'b0;
         pc_en_r     <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
`ifdef PROGRAM_LOADER_WATCHDOG_EN
         timeout_r   <= 1'b0;
`endif
      end else begin
         state_r     <= state_s;
         word_cnt_r  <= word_cnt_s;
         wr_addr_r   <= wr_addr_s;
         wr_data_r   <= wr_data_s;
         wr_en_r     <= wr_en_s;
         trunc_r     <= trunc_s;
         cyc_cnt_r   <= cyc_cnt_s;
         out_valid_r <= out_valid_s;
         out_data_r  <= out_data_s;
         s_ready_r   <= s_ready_s;
         imem_sel_r  <= imem_sel_s;
         cpu_clr_n_r <= cpu_clr_n_s;
         pc_en_r     <= pc_en_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
`ifdef PROGRAM_LOADER_WATCHDOG_EN
         timeout_r   <= timeout_s;
`endif
      end
   end

   assign s_ready           = s_ready_r;
   assign cpu_clr_n         = cpu_clr_n_r;
   assign PC_en             = pc_en_r;
   assign instr2memory_en   = imem_sel_r;
   assign I_memory_en       = wr_en_r;
   assign instr2memory_addr = {8'h00, wr_addr_r};
   assign instr_in          = wr_data_r;
   assign busy              = busy_r;
   assign done              = done_r;
   assign load_trunc        = trunc_r;
   assign cycle_count       = cyc_cnt_r;
   assign out_valid         = out_valid_r;
   assign out_data          = out_data_r;
`ifdef PROGRAM_LOADER_WATCHDOG_EN
   assign timeout           = timeout_r;
`else
   assign timeout           = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Self-checking bench for program_loader. Randomised programs and CPU output
// traffic are checked against a behavioural model: the k-th accepted stream
// word lands at address k one cycle later, a run lasts until the halt cycle
// (or the watchdog limit when compiled in), and the last nonzero CPU output
// sampled in RUN is the held sample.
// -----------------------------------------------------------------------------
module tb_program_loader;

`ifdef PROGRAM_LOADER_WATCHDOG_EN
   localparam bit WD_ON = 1'b1;
`else
   localparam bit WD_ON = 1'b0;
`endif
   localparam int WD_LIM = 16;

   logic        CLK;
   logic        clr;
   logic        start;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] s_data;
   logic        s_last;
   logic        cpu_clr_n;
   logic        PC_en;
   logic        instr2memory_en;
   logic        I_memory_en;
   logic [15:0] instr2memory_addr;
   logic [15:0] instr_in;
   logic        HLT;
   logic [15:0] OutR_D;
   logic        busy;
   logic        done;
   logic        timeout;
   logic        load_trunc;
   logic [15:0] cycle_count;
   logic        out_valid;
   logic [15:0] out_data;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] words [0:256];
   logic [15:0] exp_out = 16'h0000;

   program_loader #(.WDOG_LIMIT(16'd16)) dut (
      .CLK               (CLK),
      .clr               (clr),
      .start             (start),
      .s_valid           (s_valid),
      .s_ready           (s_ready),
      .s_data            (s_data),
      .s_last            (s_last),
      .cpu_clr_n         (cpu_clr_n),
      .PC_en             (PC_en),
      .instr2memory_en   (instr2memory_en),
      .I_memory_en       (I_memory_en),
      .instr2memory_addr (instr2memory_addr),
      .instr_in          (instr_in),
      .HLT               (HLT),
      .OutR_D            (OutR_D),
      .busy              (busy),
      .done              (done),
      .timeout           (timeout),
      .load_trunc        (load_trunc),
      .cycle_count       (cycle_count),
      .out_valid         (out_valid),
      .out_data          (out_data)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset();
      chk("rst_cpu_clr_n", cpu_clr_n, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_trunc", load_trunc, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_pc_en", PC_en, 0);
      chk("rst_sel", instr2memory_en, 0);
      chk("rst_we", I_memory_en, 0);
      chk("rst_addr", instr2memory_addr, 0);
      chk("rst_wdata", instr_in, 0);
      chk("rst_cycles", cycle_count, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
   endtask

   // Pulse start and check the fresh LOAD state.
   task automatic do_start();
      s_valid = 1'b0;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      chk("ld_s_ready", s_ready, 1);
      chk("ld_busy", busy, 1);
      chk("ld_sel", instr2memory_en, 1);
      chk("ld_cpu_clr_n", cpu_clr_n, 0);
      chk("ld_pc_en", PC_en, 0);
      chk("ld_done", done, 0);
      chk("ld_timeout", timeout, 0);
      chk("ld_trunc", load_trunc, 0);
      chk("ld_cycles", cycle_count, 0);
      chk("ld_we", I_memory_en, 0);
   endtask

   // Stream words[0..n-1]; mode 0 = random idles (idle_pct), mode 1 = valid 1,0,1...
   // Ends with the DUT in RUN after checking FLUSH and RELEASE.
   task automatic load_stream(input int n, input bit with_last, input int mode, input int idle_pct);
      int k    = 0;
      int acc  = 0;
      int iter = 0;
      bit fin  = 1'b0;
      bit v;
      bit exp_trunc;
      while (!fin && iter < 4000) begin
         if (mode == 1) v = (k < n) && (iter % 2 == 0);
         else           v = (k < n) && ($urandom_range(99) >= idle_pct);
         s_valid = v;
         s_data  = (k < n) ? words[k] : 16'h0000;
         s_last  = with_last && (k == n - 1);
         HLT     = 1'($urandom_range(1));
         tick();
         iter++;
         if (v) begin
            chk("wr_en", I_memory_en, 1);
            chk("wr_addr", instr2memory_addr, acc);
            chk("wr_data", instr_in, words[k]);
            acc++;
            if (s_last || acc == 256) fin = 1'b1;
            k++;
         end else begin
            chk("wr_idle", I_memory_en, 0);
         end
         chk("s_ready", s_ready, fin ? 0 : 1);
      end
      chk("load_budget", fin, 1);
      // FLUSH: final write in flight; offer one more word that must be refused.
      chk("fl_sel", instr2memory_en, 1);
      chk("fl_cpu_clr_n", cpu_clr_n, 0);
      chk("fl_busy", busy, 1);
      s_valid = 1'b1;
      s_data  = 16'hDEAD;
      s_last  = 1'b0;
      HLT     = 1'b0;
      tick();
      chk("rel_we", I_memory_en, 0);
      chk("rel_sel", instr2memory_en, 0);
      chk("rel_cpu_clr_n", cpu_clr_n, 1);
      chk("rel_pc_en", PC_en, 0);
      chk("rel_s_ready", s_ready, 0);
      s_valid = 1'b0;
      tick();
      exp_trunc = (acc == 256) && !(with_last && n == 256);
      chk("run_pc_en", PC_en, 1);
      chk("run_busy", busy, 1);
      chk("run_we", I_memory_en, 0);
      chk("run_trunc", load_trunc, exp_trunc);
      chk("run_cpu_clr_n", cpu_clr_n, 1);
   endtask

   // Run until halt at cycle hlt_at (or watchdog). out_mode 0: OutR_D zero,
   // 1: 16'h00A5 on cycle 3 only, 2: random sparse values.
   task automatic run_phase(input int hlt_at, input int out_mode);
      logic [15:0] drv;
      bit          ex = 1'b0;
      int          last_c = 0;
      for (int c = 1; c <= 200 && !ex; c++) begin
         HLT = (c == hlt_at);
         if (out_mode == 2)
            drv = ($urandom_range(3) == 0) ? 16'($urandom_range(65535, 1)) : 16'h0000;
         else if (out_mode == 1 && c == 3)
            drv = 16'h00A5;
         else
            drv = 16'h0000;
         OutR_D = drv;
         start  = (c == 2);
         tick();
         start = 1'b0;
         if (drv != 16'h0000) exp_out = drv;
         ex = (c == hlt_at) || (WD_ON && c >= WD_LIM);
         last_c = c;
         chk("run_out_valid", out_valid, drv != 16'h0000);
         chk("run_out_data", out_data, exp_out);
         chk("run_cycles", cycle_count, c);
         chk("run_done", done, ex);
         chk("run_pc", PC_en, !ex);
         chk("run_busy_flag", busy, !ex);
         chk("run_timeout", timeout, ex && (c != hlt_at));
         chk("run_cpu_on", cpu_clr_n, 1);
      end
      chk("run_exit_budget", ex, 1);
      // One cycle parked in DONE: CPU output must not be captured.
      HLT    = 1'b0;
      OutR_D = 16'h1234;
      tick();
      OutR_D = 16'h0000;
      chk("dn_out_valid", out_valid, 0);
      chk("dn_out_data", out_data, exp_out);
      chk("dn_done", done, 1);
      chk("dn_cycles", cycle_count, last_c);
      chk("dn_pc_en", PC_en, 0);
   endtask

   initial begin
      clr = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 16'h0000;
      s_last = 1'b0; HLT = 1'b0; OutR_D = 16'h0000;
      tick();
      tick();
      clr = 1'b0;
      check_reset();

      // Three words back to back, halt after 10 RUN cycles.
      words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
      do_start();
      load_stream(3, 1'b1, 0, 0);
      run_phase(10, 0);

      // Valid toggling 1,0,1; single 16'h00A5 output pulse.
      words[0] = 16'($urandom); words[1] = 16'($urandom);
      do_start();
      load_stream(2, 1'b1, 1, 0);
      run_phase(6, 1);

      // 256 words without s_last: truncation, 257th word refused.
      for (int i = 0; i < 257; i++) words[i] = 16'($urandom);
      do_start();
      load_stream(257, 1'b0, 0, 30);
      run_phase(25, 2);

      // Random short programs.
      for (int p = 0; p < 3; p++) begin
         int n;
         n = $urandom_range(20, 1);
         for (int i = 0; i < n; i++) words[i] = 16'($urandom);
         do_start();
         load_stream(n, 1'b1, 0, $urandom_range(60, 0));
         run_phase($urandom_range(30, 3), 2);
      end

      // Reset on the same edge as an accepted beat: write abandoned.
      do_start();
      s_valid = 1'b1;
      s_data  = 16'hBEEF;
      clr     = 1'b1;
      tick();
      clr     = 1'b0;
      s_valid = 1'b0;
      exp_out = 16'h0000;
      check_reset();

      // Reset in the middle of RUN.
      words[0] = 16'h0A0A; words[1] = 16'h0B0B;
      do_start();
      load_stream(2, 1'b1, 0, 0);
      for (int c = 0; c < 5; c++) begin
         OutR_D = 16'h0042;
         tick();
      end
      OutR_D = 16'h0000;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check_reset();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter WDOG_LIMIT, default 16'hFFFF, maximum RUN cycles before timeout (used only with watchdog compiled in).
REQ-002 CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 clr  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 start  input  1  begin load of a new program; honoured only in IDLE or DONE.
REQ-005 s_valid / s_ready / s_data  input / output / input  1 / 1 / 16  instruction stream; beat transfers when s_valid && s_ready.
REQ-006 s_last  input  1  marks final instruction word of the stream.
REQ-007 cpu_clr_n  output  1  CPU reset, active-low.
REQ-008 PC_en  output  1  CPU program-counter enable.
REQ-009 instr2memory_en / I_memory_en  output  1 / 1  imem address-override select / imem write strobe.
REQ-010 instr2memory_addr / instr_in  output  16 / 16  imem write address (bits 15:8 always 0) / write data.
REQ-011 HLT / OutR_D  input  1 / 16  CPU halt flag / CPU output-register data.
REQ-012 busy, done, timeout, load_trunc  output  1 each  status.
REQ-013 cycle_count  output  16  RUN cycles of last execution.
REQ-014 out_valid / out_data  output  1 / 16  captured CPU output sample.

Function
REQ-015 All outputs registered; state machine IDLE, LOAD, FLUSH, RELEASE, RUN, DONE.
REQ-016 IDLE: start=1 -> LOAD; word counter := 0; cpu_clr_n := 0.
REQ-017 LOAD: s_ready=1, instr2memory_en=1, cpu_clr_n=0, PC_en=0; ignores HLT.
REQ-018 Accepted beat at edge N -> cycle after N: I_memory_en=1, instr2memory_addr=counter, instr_in=s_data; counter+1; back-to-back beats give back-to-back writes.
REQ-019 Cycles with no accepted beat: I_memory_en=0.
REQ-020 Accepted beat with s_last=1, or accepted beat at address 8'hFF -> FLUSH; s_ready=0 from next cycle.
REQ-021 Beat at 8'hFF with s_last=0: load_trunc:=1; further stream words are not accepted.
REQ-022 FLUSH: one cycle, completes final imem write, then RELEASE.
REQ-023 RELEASE: one cycle; instr2memory_en=0, I_memory_en=0, cpu_clr_n=1, PC_en=0; then RUN.
REQ-024 RUN: PC_en=1; cycle_count increments each RUN cycle, saturating at 16'hFFFF.
REQ-025 RUN: HLT=1 sampled -> DONE; PC_en=0 from next cycle.
REQ-026 RUN: OutR_D != 0 sampled -> next cycle out_valid=1 for one cycle, out_data=OutR_D; out_data holds until next capture.
REQ-027 DONE: done=1, cpu_clr_n=1 (CPU state preserved), PC_en=0; start=1 -> LOAD, clears done, timeout, load_trunc, cycle_count.
REQ-028 busy=1 in LOAD, FLUSH, RELEASE, RUN.
REQ-029 start while busy: ignored.

Reset
REQ-030 clr=1 at any edge, in any state: next cycle state=IDLE, cpu_clr_n=0, all other outputs 0 (out_data, cycle_count, counter cleared).
REQ-031 Reset mid-LOAD abandons pending write: I_memory_en=0 on next cycle.

Configuration
REQ-032 Macro PROGRAM_LOADER_WATCHDOG_EN defined: in RUN, cycle_count reaching WDOG_LIMIT without HLT -> DONE with timeout=1, PC_en=0 next cycle.
REQ-033 Macro undefined: no watchdog logic; timeout tied 0; RUN exits only on HLT or clr.

Verification
REQ-034 Load 3 words 16'h1111,16'h2222,16'h3333 (s_last on 3rd), no stalls -> I_memory_en high 3 consecutive cycles, addrs 0,1,2, FLUSH, RELEASE, RUN; load_trunc=0.
REQ-035 s_valid toggling 1,0,1 -> writes only on cycles after accepted beats; addresses contiguous 0,1.
REQ-036 256 words, s_last never set -> last write addr 16'h00FF, load_trunc=1, s_ready=0 thereafter, 257th word not accepted.
REQ-037 RUN, HLT raised after 10 cycles -> done=1, cycle_count=10, PC_en=0, cpu_clr_n=1.
REQ-038 RUN, OutR_D=16'h00A5 one cycle then 0 -> out_valid single pulse, out_data=16'h00A5 held; OutR_D=0 -> no pulse.
REQ-039 WATCHDOG_EN, WDOG_LIMIT=16, HLT never raised -> timeout=1, done=1, cycle_count=16; clr mid-RUN -> IDLE, cpu_clr_n=0 next cycle.
